bias_startup_ctrl: RTL

Digital power-up sequencer for the EG1d80V bias/bandgap cell, placed directly upstream of it in the core-supply domain. It drives the cell's enable, VBIAS-enable, bandgap-startup and trim inputs. It also synchronises and debounces the cell's active-low valid flag, and reports READY or FAULT to the power-management logic.

---
 rtl/bias_startup_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bias_startup_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bias_startup_ctrl
// Brief    : Power-up sequencer and valid-flag debouncer for the EG1d80V
//            bias/bandgap cell. Define BIAS_STARTUP_RETRY_EN to retry startup.
// Revision : 1.0
// ============================================================================
module bias_startup_ctrl #(
    parameter int STARTUP_CYC  = 64,
    parameter int SETTLE_CYC   = 256,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       REQ_I,
    input  logic       VBIAS_REQ_I,
    input  logic [3:0] TRIM_BIAS_CFG_I,
    input  logic [4:0] TRIM_CURV_CFG_I,
    input  logic [4:0] TRIM_VBG_CFG_I,
    input  logic       BG_VALID_N_I,
    output logic       EN_O,
    output logic       EN_VBIAS_O,
    output logic       BG_STARTUP_O,
    output logic [3:0] TRIM_BIAS_O,
    output logic [4:0] TRIM_CURV_O,
    output logic [4:0] TRIM_VBG_O,
    output logic       READY_O,
    output logic       FAULT_O,
    output logic [2:0] STATE_O
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_STARTUP = 3'd1,
        S_SETTLE  = 3'd2,
        S_CHECK   = 3'd3,
        S_READY   = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [15:0] c_startup_last = 16'(STARTUP_CYC - 1);
    localparam logic [15:0] c_settle_last  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  c_deb_last     = 8'(DEBOUNCE_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  deb_q, deb_d;
    logic        en_q, en_d;
    logic        en_vbias_q, en_vbias_d;
    logic        bg_startup_q, bg_startup_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic [3:0]  trim_bias_q;
    logic [4:0]  trim_curv_q;
    logic [4:0]  trim_vbg_q;
    logic        w_vld;
    logic        w_fail;

`ifdef BIAS_STARTUP_RETRY_EN
    logic [3:0]  retry_q, retry_d;
`else
    logic        w_unused_retry;
    assign w_unused_retry = ^4'(MAX_RETRY);
`endif

    // The cell flag is active-low; sync_q[1] is the metastability-safe copy.
    assign w_vld = ~sync_q[1];

    always_comb begin
        state_d = state_q;
        w_fail  = 1'b0;
        case (state_q)
            S_OFF:     if (REQ_I) state_d = S_STARTUP;
            S_STARTUP: if (timer_q == c_startup_last) state_d = S_SETTLE;
            S_SETTLE:  if (timer_q == c_settle_last) state_d = S_CHECK;
            S_CHECK: begin
                if (w_vld && (deb_q == c_deb_last)) begin
                    state_d = S_READY;
                end else if (timer_q == c_timeout_last) begin
                    w_fail = 1'b1;
                end
            end
            S_READY:   if (!w_vld && (deb_q == c_deb_last)) w_fail = 1'b1;
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_OFF;
        endcase

`ifdef BIAS_STARTUP_RETRY_EN
        retry_d = retry_q;
        if (w_fail) begin
            if (retry_q < 4'(MAX_RETRY)) begin
                retry_d = retry_q + 4'd1;
                state_d = S_STARTUP;
            end else begin
                state_d = S_FAULT;
            end
        end
        if (state_q == S_OFF) retry_d = 4'd0;
`else
        if (w_fail) state_d = S_FAULT;
`endif

        if (!REQ_I) state_d = S_OFF;

        timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        deb_d   = 8'd0;
        if ((state_q == S_CHECK && w_vld) || (state_q == S_READY && !w_vld)) begin
            deb_d = (deb_q == 8'hFF) ? deb_q : deb_q + 8'd1;
        end
        if (state_d != state_q) begin
            timer_d = 16'd0;
            deb_d   = 8'd0;
        end

        // Outputs are decoded from the next state so they change with STATE_O.
        en_d         = state_d inside {S_STARTUP, S_SETTLE, S_CHECK, S_READY};
        bg_startup_d = (state_d == S_STARTUP);
        ready_d      = (state_d == S_READY);
        fault_d      = (state_d == S_FAULT);
        en_vbias_d   = (state_d == S_READY) && VBIAS_REQ_I;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q      <= S_OFF;
            sync_q       <= 2'b11;
            timer_q      <= 16'd0;
            deb_q        <= 8'd0;
            en_q         <= 1'b0;
            en_vbias_q   <= 1'b0;
            bg_startup_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            trim_bias_q  <= 4'd0;
            trim_curv_q  <= 5'd0;
            trim_vbg_q   <= 5'd0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], BG_VALID_N_I};
            timer_q      <= timer_d;
            deb_q        <= deb_d;
            en_q         <= en_d;
            en_vbias_q   <= en_vbias_d;
            bg_startup_q <= bg_startup_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            // Trims track the configuration only while the cell is off.
            if (state_q == S_OFF) begin
                trim_bias_q <= TRIM_BIAS_CFG_I;
                trim_curv_q <= TRIM_CURV_CFG_I;
                trim_vbg_q  <= TRIM_VBG_CFG_I;
            end
        end
    end

`ifdef BIAS_STARTUP_RETRY_EN
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            retry_q <= 4'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign EN_O         = en_q;
    assign EN_VBIAS_O   = en_vbias_q;
    assign BG_STARTUP_O = bg_startup_q;
    assign TRIM_BIAS_O  = trim_bias_q;
    assign TRIM_CURV_O  = trim_curv_q;
    assign TRIM_VBG_O   = trim_vbg_q;
    assign READY_O      = ready_q;
    assign FAULT_O      = fault_q;
    assign STATE_O      = state_q;

endmodule
`default_nettype wire
